alu_op_issuer: RTL
==================

// Module: alu_op_issuer
// PURPOSE
//  Requester-side master for the sequential ALU request/accept interface. Buffers commands
//  from an upstream valid/ready stream and drives one ALU operation at a time. Holds operands
//  and the one-hot op lines stable until the ALU accepts. Returns {q, ovf} in order on a
//  downstream valid/ready stream. Sits between the control sequencer and sequential_alu.
// PARAMETERS
//  DATA_WIDTH      10   operand/result width, two's complement
//  CMD_DEPTH       2    command FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES  64   cycles to wait for i_accept before abort (only with macro)
// PORTS
//  i_clk        in   1           clock, rising edge
//  i_nrst       in   1           asynchronous active-low reset
//  i_cmd_valid  in   1           command present
//  i_cmd_op     in   2           00 add, 01 sub, 10 mul, 11 div
//  i_cmd_a      in   DATA_WIDTH  operand a
//  i_cmd_b      in   DATA_WIDTH  operand b
//  o_cmd_ready  out  1           FIFO not full
//  o_a          out  DATA_WIDTH  ALU operand a
//  o_b          out  DATA_WIDTH  ALU operand b
//  o_add/o_sub/o_mul/o_div  out 1 each  one-hot ALU op request; all 0 = idle
//  i_q          in   DATA_WIDTH  ALU result
//  i_ovf        in   1           ALU overflow
//  i_accept     in   1           ALU done pulse; i_q/i_ovf valid this cycle
//  o_rsp_valid  out  1           response present
//  o_rsp_q      out  DATA_WIDTH  result
//  o_rsp_ovf    out  1           overflow, or timeout abort
//  i_rsp_ready  in   1           downstream takes response
//  o_timeout    out  1           sticky timeout flag
// BEHAVIOUR
//  Reset: every output 0 except o_cmd_ready=1. FIFO empty, state IDLE.
//  Reset mid-op drops op lines at once and discards buffered and in-flight commands.
//  Cmd handshake: valid&ready at edge. Push when full is impossible (ready=0).
//  Simultaneous push+pop allowed at any fill level.
//  FSM IDLE: FIFO non-empty -> pop, register a/b/op, go ISSUE. Op lines are high the next cycle.
//  FSM ISSUE: exactly one op line high; o_a/o_b/op held stable. i_accept sampled high ->
//    capture i_q, i_ovf into response regs, go RESP. Op lines low from the next cycle.
//  FSM RESP: o_rsp_valid=1, data stable. i_rsp_ready -> IDLE. Pop is earliest next edge.
//  Op lines are low for >=1 cycle between ops. i_accept is ignored outside ISSUE.
//  Latency: cmd push at edge N -> op lines high after N+1.
//    i_accept at edge M -> o_rsp_valid high after M.
//  Responses leave in command order; none are dropped or duplicated.
//  FIFO pointers wrap modulo CMD_DEPTH with an extra wrap bit for full/empty.
// CONFIGURATION
//  ALU_ISSUER_TIMEOUT_EN defined:
//    - wait counter clears on ISSUE entry and counts each ISSUE cycle.
//    - reaching TIMEOUT_CYCLES without i_accept -> drop op lines, rsp q=0 ovf=1, go RESP,
//      set o_timeout (cleared only by reset).
//    - i_accept on the same cycle as expiry wins: normal response.
//  Not defined: no counter; ISSUE waits forever; o_timeout tied 0.
// STRUCTURE
//  alu_issuer_pkg: op codes OP_ADD..OP_DIV, FSM state encodings S_IDLE/S_ISSUE/S_RESP.
//  Sub-module alu_cmd_fifo: synchronous FIFO, DATA_WIDTH*2+2 wide, CMD_DEPTH deep.
//  Top holds the FSM, op decode, response regs and optional timer.
// TESTING (DATA_WIDTH=10; ALU model with random 1-8 cycle accept latency)
//  add(1,1), rsp_ready=1:
//    -> one op line high until accept; rsp q=2 ovf=0; op lines low 1 cycle after accept.
//  mul(7,-7) then div(10,0) back-to-back:
//    -> rsp q=10'h3CF ovf=0, then ovf=1, in order.
//  i_rsp_ready=0, push 4 cmds, CMD_DEPTH=2:
//    -> cmd_ready low after the 3rd push; next pops only after rsp drained; order kept.
//  i_nrst low 1 cycle during ISSUE:
//    -> op lines/rsp_valid 0 immediately; FIFO empty; next cmd processes normally.
//  With ALU_ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=16, ALU never accepts:
//    -> after 16 ISSUE cycles rsp q=0 ovf=1, o_timeout=1 sticky.
//  Random 50000 ops vs reference ALU model:
//    -> every rsp matches in order; op lines never change while held.

Source files
------------

// File: rtl/alu_issuer_pkg.sv
// Shared types for the ALU op issuer: command op codes, FSM state encodings
// and a decoder from op code to the one-hot {div, mul, sub, add} request lines.
package alu_issuer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RESP  = 2'b10
  } state_e;

  // Returns {div, mul, sub, add} with exactly one bit set.
  function automatic logic [3:0] op_onehot(input op_e op);
    logic [3:0] oh;
    case (op)
      OP_ADD:  oh = 4'b0001;
      OP_SUB:  oh = 4'b0010;
      OP_MUL:  oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full (same index, different lap) and empty (identical pointers) are
// distinguishable. Push on full and pop on empty are ignored.
module alu_cmd_fifo
  import alu_issuer_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer advance; push and pop may happen together at any fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Requester-side master for the sequential ALU. Buffers upstream commands,
// issues one ALU op at a time with operands and one-hot op lines held until
// accept, and returns {q, ovf} in command order downstream.
// Optional ISSUE watchdog enabled by defining ALU_ISSUER_TIMEOUT_EN.
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int DATA_WIDTH     = 10,
  parameter int CMD_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_b,
  output logic                  o_cmd_ready,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic                  o_add,
  output logic                  o_sub,
  output logic                  o_mul,
  output logic                  o_div,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_ovf,
  input  logic                  i_accept,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_q,
  output logic                  o_rsp_ovf,
  input  logic                  i_rsp_ready,
  output logic                  o_timeout
);

  localparam int CMD_W = 2*DATA_WIDTH + 2;

  state_e                state;
  state_e                state_next;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [CMD_W-1:0]      push_data;
  logic [CMD_W-1:0]      pop_data;
  op_e                   op_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] rsp_q_reg;
  logic                  rsp_ovf_reg;
  logic                  accept_ok;
  logic                  expire;

  assign o_cmd_ready = !fifo_full;
  assign push        = i_cmd_valid && !fifo_full;
  assign push_data   = {i_cmd_op, i_cmd_a, i_cmd_b};
  assign pop         = (state == S_IDLE) && !fifo_empty;
  assign accept_ok   = (state == S_ISSUE) && i_accept;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_nrst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef ALU_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_reg;

  // A same-cycle accept takes priority over expiry.
  assign expire    = (state == S_ISSUE) && !i_accept &&
                     (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign o_timeout = timeout_reg;

  // Wait counter is zero on ISSUE entry and counts every ISSUE cycle; the flag is sticky.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wait_cnt    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state != S_ISSUE) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + TW'(1);
      if (expire) timeout_reg <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire                = 1'b0;
  assign o_timeout             = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic: IDLE pops, ISSUE waits for accept (or expiry), RESP waits for drain.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pop) state_next = S_ISSUE;
      S_ISSUE: if (accept_ok || expire) state_next = S_RESP;
      S_RESP:  if (i_rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs: op lines only while issuing, response valid only in RESP.
  always_comb begin
    {o_div, o_mul, o_sub, o_add} = 4'b0000;
    if (state == S_ISSUE) {o_div, o_mul, o_sub, o_add} = op_onehot(op_reg);
    o_rsp_valid = (state == S_RESP);
  end

  // Operand capture on pop and response capture on accept or timeout abort.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      op_reg      <= OP_ADD;
      a_reg       <= '0;
      b_reg       <= '0;
      rsp_q_reg   <= '0;
      rsp_ovf_reg <= 1'b0;
    end else begin
      if (pop) begin
        op_reg <= op_e'(pop_data[CMD_W-1 -: 2]);
        a_reg  <= pop_data[2*DATA_WIDTH-1 -: DATA_WIDTH];
        b_reg  <= pop_data[DATA_WIDTH-1:0];
      end
      if (accept_ok) begin
        rsp_q_reg   <= i_q;
        rsp_ovf_reg <= i_ovf;
      end else if (expire) begin
        rsp_q_reg   <= '0;
        rsp_ovf_reg <= 1'b1;
      end
    end
  end

  assign o_a       = a_reg;
  assign o_b       = b_reg;
  assign o_rsp_q   = rsp_q_reg;
  assign o_rsp_ovf = rsp_ovf_reg;

endmodule
